// File: rtl/fpa_pipelined.sv
// Pipelined floating-point adder/subtractor with a parametrised exponent and fraction width.
// Latency: 3 cycles (unpack/align, add/sub, normalise/round/pack), one result per cycle.
// Backpressure: all stages advance together only when the output slot is empty or being taken.
module fpa_pipelined #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              op_sub,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] result,
  output logic                              flag_overflow,
  output logic                              flag_underflow,
  output logic                              flag_invalid
);
  localparam int E    = EXP_WIDTH;
  localparam int M    = MANTISSA_WIDTH;
  localparam int SW   = M + 4;          // hidden bit + fraction + guard/round/sticky
  localparam int EMAX = 2**E - 1;

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // ---------------- stage 1: unpack, compare, swap, align ----------------
  logic sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b;
  logic [E-1:0] ea, eb;
  logic [M-1:0] fa, fb;
  logic [E+M-1:0] mag_a, mag_b;

  assign sa    = a[E+M];
  assign sb    = b[E+M] ^ op_sub;
  assign ea    = a[E+M-1:M];
  assign eb    = b[E+M-1:M];
  assign fa    = a[M-1:0];
  assign fb    = b[M-1:0];
  assign za    = (ea == '0);
  assign zb    = (eb == '0);
  assign inf_a = (ea == '1) && (fa == '0);
  assign inf_b = (eb == '1) && (fb == '0);
  assign nan_a = (ea == '1) && (fa != '0);
  assign nan_b = (eb == '1) && (fb != '0);
  // subnormals flush to zero, so they compare as the smallest magnitude
  assign mag_a = za ? '0 : a[E+M-1:0];
  assign mag_b = zb ? '0 : b[E+M-1:0];

  logic           l_sign, s_sign;
  logic [E-1:0]   l_exp, s_exp, diff;
  logic [M:0]     l_sig, s_sig;
  logic [2*SW-1:0] ext, ext_sh;
  logic [SW-1:0]  al_s;
  int             sh;

  // order operands by magnitude, then right-shift the smaller one keeping a sticky bit
  always_comb begin
    if (mag_a >= mag_b) begin
      l_sign = sa;  s_sign = sb;
      l_exp  = za ? '0 : ea;  s_exp = zb ? '0 : eb;
      l_sig  = za ? '0 : {1'b1, fa};  s_sig = zb ? '0 : {1'b1, fb};
    end else begin
      l_sign = sb;  s_sign = sa;
      l_exp  = zb ? '0 : eb;  s_exp = za ? '0 : ea;
      l_sig  = zb ? '0 : {1'b1, fb};  s_sig = za ? '0 : {1'b1, fa};
    end
    diff   = l_exp - s_exp;
    sh     = (int'(diff) > SW) ? SW : int'(diff);
    ext    = {s_sig, 3'b000, {SW{1'b0}}};
    ext_sh = ext >> sh;
    al_s   = ext_sh[2*SW-1:SW];
    al_s[0] = al_s[0] | (|ext_sh[SW-1:0]);
  end

  logic           v1, s1_sign, s1_eff_sub, s1_inv, s1_inf, s1_inf_sign;
  logic [E-1:0]   s1_exp;
  logic [SW-1:0]  s1_sig_l, s1_sig_s;

  // stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; s1_sign <= 1'b0; s1_eff_sub <= 1'b0; s1_inv <= 1'b0;
      s1_inf <= 1'b0; s1_inf_sign <= 1'b0; s1_exp <= '0; s1_sig_l <= '0; s1_sig_s <= '0;
    end else if (advance) begin
      v1          <= in_valid;
      s1_sign     <= l_sign;
      s1_eff_sub  <= l_sign ^ s_sign;
      s1_inv      <= nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
      s1_inf      <= inf_a | inf_b;
      s1_inf_sign <= inf_a ? sa : sb;
      s1_exp      <= l_exp;
      s1_sig_l    <= {l_sig, 3'b000};
      s1_sig_s    <= al_s;
    end
  end

  // ---------------- stage 2: significand add/sub ----------------
  logic [SW:0] sum;
  assign sum = s1_eff_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                          : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});

  logic         v2, s2_sign, s2_inv, s2_inf, s2_inf_sign;
  logic [E-1:0] s2_exp;
  logic [SW:0]  s2_sum;

  // stage 2 register; an exact cancellation is forced to +0 here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; s2_sign <= 1'b0; s2_inv <= 1'b0; s2_inf <= 1'b0;
      s2_inf_sign <= 1'b0; s2_exp <= '0; s2_sum <= '0;
    end else if (advance) begin
      v2          <= v1;
      s2_sign     <= (s1_eff_sub && sum == '0) ? 1'b0 : s1_sign;
      s2_inv      <= s1_inv;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  int           lz, exp_n, exp_r;
  logic [SW-1:0] norm;
  logic [M:0]   mant;
  logic [M+1:0] rounded;
  logic [M-1:0] frac;
  logic         round_up;
  logic [E+M:0] res_n;
  logic         ov_n, uf_n, inv_n;

  // leading-zero normalisation, RNE on guard/round+sticky, then exception priority
  always_comb begin
    lz = SW;
    for (int i = 0; i < SW; i++) if (s2_sum[i]) lz = SW - 1 - i;
    if (s2_sum[SW]) begin
      norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      exp_n = int'(s2_exp) + 1;
    end else begin
      norm  = s2_sum[SW-1:0] << lz;
      exp_n = int'(s2_exp) - lz;
    end
    mant     = norm[SW-1:3];
    round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
    rounded  = {1'b0, mant} + {{(M+1){1'b0}}, round_up};
    if (rounded[M+1]) begin
      exp_r = exp_n + 1;
      frac  = rounded[M:1];
    end else begin
      exp_r = exp_n;
      frac  = rounded[M-1:0];
    end
    ov_n = 1'b0; uf_n = 1'b0; inv_n = 1'b0;
    if (s2_inv) begin
      res_n = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      inv_n = 1'b1;
    end else if (s2_inf) begin
      res_n = {s2_inf_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (s2_sum == '0) begin
      res_n = {s2_sign, {(E+M){1'b0}}};
    end else if (exp_r >= EMAX) begin
      res_n = {s2_sign, {E{1'b1}}, {M{1'b0}}};
      ov_n  = 1'b1;
    end else if (exp_n <= 0) begin
      res_n = {s2_sign, {(E+M){1'b0}}};
      uf_n  = 1'b1;
    end else begin
      res_n = {s2_sign, E'(exp_r), frac};
    end
  end

  // output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; result <= '0;
      flag_overflow <= 1'b0; flag_underflow <= 1'b0; flag_invalid <= 1'b0;
    end else if (advance) begin
      out_valid      <= v2;
      result         <= res_n;
      flag_overflow  <= ov_n;
      flag_underflow <= uf_n;
      flag_invalid   <= inv_n;
    end
  end
endmodule

// File: tb/tb_fpa_pipelined.sv
// Bench for fpa_pipelined: directed cases, backpressure, reset, and random traffic
// checked against an exact-arithmetic reference model through a scoreboard.
module tb_fpa_pipelined;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic        fo, fu, fi;
  logic [31:0] a, b, result;

  logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
  logic        h_fo, h_fu, h_fi;
  logic [15:0] ha, hb, h_result;

  fpa_pipelined dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_overflow(fo), .flag_underflow(fu), .flag_invalid(fi));

  fpa_pipelined #(.EXP_WIDTH(5), .MANTISSA_WIDTH(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op_sub(h_op_sub),
    .a(ha), .b(hb), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .flag_overflow(h_fo), .flag_underflow(h_fu), .flag_invalid(h_fi));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // exact arithmetic: place both significands on a common integer grid, add, round RNE
  function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic sx, sy, s, g, st, up, nx, ny, ix, iy;
    int ex, ey, p, eb, shf;
    logic [299:0] mx, my, mag, one, mask;
    logic [24:0] kept;
    sx = x[31]; sy = y[31] ^ sub;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0); ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0); iy = (ey == 255) && (y[22:0] == 0);
    if (nx || ny || (ix && iy && sx != sy)) return {32'h7FC00000, 3'b001};
    if (ix) return {sx, 8'hFF, 23'h0, 3'b000};
    if (iy) return {sy, 8'hFF, 23'h0, 3'b000};
    mx = '0; my = '0;
    if (ex != 0) mx = 300'({1'b1, x[22:0]}) << (ex - 1);
    if (ey != 0) my = 300'({1'b1, y[22:0]}) << (ey - 1);
    if (sx == sy) begin mag = mx + my; s = sx; end
    else if (mx >= my) begin mag = mx - my; s = sx; end
    else begin mag = my - mx; s = sy; end
    if (mag == 0) return {((sx == sy) ? sx : 1'b0), 31'h0, 3'b000};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    eb = p - 22;
    if (eb <= 0) return {s, 31'h0, 3'b010};
    shf = p - 23;
    kept = 25'(mag >> shf);
    g = 1'b0; st = 1'b0;
    if (shf > 0) begin
      g = mag[shf-1];
      one = 300'd1;
      mask = (one << (shf - 1)) - 300'd1;
      st = |(mag & mask);
    end
    up = g && (st || kept[0]);
    kept = kept + 25'(up);
    if (kept[24]) begin kept = kept >> 1; eb++; end
    if (eb >= 255) return {s, 8'hFF, 23'h0, 3'b100};
    return {s, 8'(eb), kept[22:0], 3'b000};
  endfunction

  function automatic logic [31:0] rnd_fp(input int near_e);
    int k, e;
    logic s;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    s = 1'($urandom);
    f = 23'($urandom);
    if (k == 0) return {s, 8'hFF, 23'h0};
    if (k == 1) return {s, 8'hFF, f | 23'h1};
    if (k == 2) return {s, 8'h00, f};
    if (k == 3) e = ($urandom_range(0, 1) != 0) ? 254 : 1;
    else if (k < 12) e = near_e + int'($urandom_range(0, 6)) - 3;
    else e = int'($urandom_range(1, 254));
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {s, 8'(e), f};
  endfunction

  logic [34:0] sbq[$];
  logic [34:0] last_out, held;
  logic        got_out, acc;
  int          cyc_n = 0, out_cyc = 0, delivered = 0;

  // one clock period: inputs already driven at the negedge; log transfers of the coming posedge
  task automatic cyc();
    #1;
    acc = in_valid && in_ready;
    if (acc) sbq.push_back(ref_add(a, b, op_sub));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else chk("scoreboard", {result, fo, fu, fi}, sbq.pop_front());
      last_out = {result, fo, fu, fi};
      got_out  = 1'b1;
      out_cyc  = cyc_n;
      delivered++;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic sub, input logic [34:0] exp);
    int c0;
    out_ready = 1'b1; in_valid = 1'b1; a = x; b = y; op_sub = sub;
    c0 = cyc_n;
    got_out = 1'b0;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !got_out; k++) cyc();
    if (!got_out) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk(tag, last_out, exp);
      chk({tag, "_lat"}, 64'(out_cyc - c0), 64'd3);
    end
  endtask

  logic [31:0] x, y;
  logic [31:0] bp_a[6], bp_b[6];
  logic        bp_op[6];
  int          lat, sent, d0, stall_left;

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_op_sub = 1'b0; ha = '0; hb = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {result, fo, fu, fi}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // half-precision instance
    ha = 16'h3C00; hb = 16'h3C00; h_in_valid = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b0;
    lat = 1;
    #1;
    while (!h_out_valid && lat < 10) begin @(negedge clk); #1; lat++; end
    chk("half_add", {h_result, h_fo, h_fu, h_fi}, {16'h4000, 3'b000});
    chk("half_lat", 64'(lat), 64'd3);
    @(negedge clk);

    directed("add_one_one", 32'h3F800000, 32'h3F800000, 1'b0, {32'h40000000, 3'b000});
    directed("sub_three_one", 32'h40400000, 32'h3F800000, 1'b1, {32'h40000000, 3'b000});
    directed("sub_equal", 32'h3F800000, 32'h3F800000, 1'b1, {32'h00000000, 3'b000});
    directed("rne_tie_even", 32'h3F800000, 32'h33800000, 1'b0, {32'h3F800000, 3'b000});
    directed("rne_tie_odd", 32'h3F800001, 32'h33800000, 1'b0, {32'h3F800002, 3'b000});
    directed("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, {32'h7FC00000, 3'b001});
    directed("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {32'h7F800000, 3'b100});
    directed("underflow", 32'h00800001, 32'h00800000, 1'b1, {32'h00000000, 3'b010});
    directed("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, {32'h80000000, 3'b000});

    // backpressure: six ops, consumer stalls 5 cycles once results appear
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = rnd_fp(127); bp_b[i] = rnd_fp(int'(bp_a[i][30:23])); bp_op[i] = 1'($urandom);
    end
    d0 = delivered; sent = 0; stall_left = -1;
    for (int k = 0; k < 40 && (delivered - d0) < 6; k++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin a = bp_a[sent]; b = bp_b[sent]; op_sub = bp_op[sent]; end
      if (stall_left < 0 && out_valid) stall_left = 5;
      out_ready = !(stall_left > 0);
      if (stall_left > 0) begin
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        if (stall_left == 5) held = {result, fo, fu, fi};
        else chk("bp_hold", {result, fo, fu, fi}, held);
        stall_left--;
      end
      cyc();
      if (acc) sent++;
    end
    chk("bp_delivered", 64'(delivered - d0), 64'd6);
    in_valid = 1'b0; out_ready = 1'b1;

    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = rnd_fp(100); b = rnd_fp(100); op_sub = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_result", {result, fo, fu, fi}, 0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rst_no_stale", out_valid, 0);
      cyc();
    end
    directed("post_rst", 32'h40400000, 32'h3F800000, 1'b0, {32'h40800000, 3'b000});

    // random traffic with random consumer stalls
    for (int k = 0; k < 600; k++) begin
      x = rnd_fp(int'($urandom_range(1, 254)));
      y = rnd_fp(int'(x[30:23]));
      if ($urandom_range(0, 15) == 0) y = x;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = x; b = y; op_sub = 1'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) cyc();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
